bike_light_ctrl: RTL

- Control/producer side of the rear-light path. Debounces one push button and steps a 2-bit light-mode state on each press.
- Generates the fast and slow blink waveforms the rear-light mux consumes.
- Outputs state[1:0], fast_blink and slow_blink connect directly to the rear-light selector's inputs of the same names.

---
 rtl/bike_light_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bike_light_ctrl.sv
// bike_light_ctrl: rear-light control side -- debounced mode button, 4-mode FSM, fast/slow blink sources
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   btn_in      in   raw asynchronous mode button, active-high
//   tick_en     in   one-clk timebase strobe driving both blink generators
//   state[1:0]  out  light mode: 00 OFF, 01 ON, 10 FLASH1 (fast), 11 FLASH2 (slow)
//   fast_blink  out  square wave, FAST_HALF ticks high / FAST_HALF ticks low
//   slow_blink  out  square wave, SLOW_HALF ticks high / SLOW_HALF ticks low
//
// Optional feature macro: BIKE_LIGHT_AUTO_OFF_EN
//   When defined, a non-OFF mode returns to OFF after AUTO_OFF_TICKS tick_en pulses
//   without a press. When undefined, no idle counter exists.
module bike_light_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAST_HALF       = 4,
    parameter int SLOW_HALF       = 16,
    parameter int AUTO_OFF_TICKS  = 1024,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       tick_en,
    output logic [1:0] state,
    output logic       fast_blink,
    output logic       slow_blink
);

    localparam logic [1:0] ST_OFF    = 2'b00;
    localparam logic [1:0] ST_ON     = 2'b01;
    localparam logic [1:0] ST_FLASH1 = 2'b10;
    localparam logic [1:0] ST_FLASH2 = 2'b11;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAST_MAX = CNT_W'(FAST_HALF - 1);
    localparam logic [CNT_W-1:0] SLOW_MAX = CNT_W'(SLOW_HALF - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || FAST_HALF < 1 || SLOW_HALF < 1 || AUTO_OFF_TICKS < 1) begin : g_bad_param
            $error("bike_light_ctrl: parameter below its minimum of 1");
        end
    endgenerate

    logic [1:0]       r_sync;
    logic             r_deb;
    logic             r_deb_q;
    logic             r_press;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [1:0]       r_state;
    logic             r_fast;
    logic             r_slow;
    logic [CNT_W-1:0] r_fast_cnt;
    logic [CNT_W-1:0] r_slow_cnt;

    logic             w_btn_s;
    logic             w_deb_flip;
    logic             w_timeout;
    logic             w_chg;
    logic [1:0]       w_state_nxt;

    assign w_btn_s    = r_sync[1];
    // deb flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement
    assign w_deb_flip = (w_btn_s != r_deb) && (r_deb_cnt == DEB_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b00;
            r_deb     <= 1'b0;
            r_deb_q   <= 1'b0;
            r_press   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync    <= {r_sync[0], btn_in};
            r_deb_q   <= r_deb;
            r_press   <= r_deb & ~r_deb_q;
            r_deb_cnt <= (w_btn_s == r_deb || w_deb_flip) ? '0 : r_deb_cnt + 1'b1;
            if (w_deb_flip)
                r_deb <= ~r_deb;
        end
    end

`ifdef BIKE_LIGHT_AUTO_OFF_EN
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(AUTO_OFF_TICKS - 1);

    logic [CNT_W-1:0] r_idle_cnt;

    // a coincident press wins over the timeout
    assign w_timeout = tick_en && !r_press && (r_state != ST_OFF) && (r_idle_cnt == IDLE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idle_cnt <= '0;
        else if (r_press || w_timeout || r_state == ST_OFF)
            r_idle_cnt <= '0;
        else if (tick_en)
            r_idle_cnt <= r_idle_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (r_press)
            w_state_nxt = (r_state == ST_OFF)    ? ST_ON     :
                          (r_state == ST_ON)     ? ST_FLASH1 :
                          (r_state == ST_FLASH1) ? ST_FLASH2 : ST_OFF;
        else if (w_timeout)
            w_state_nxt = ST_OFF;
    end

    // every press changes the mode; a timeout only fires outside OFF
    assign w_chg = r_press | w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_OFF;
        else
            r_state <= w_state_nxt;
    end

    // a mode change restarts both blink phases high so a new flash mode
    // always opens with a full high half-period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fast     <= 1'b1;
            r_fast_cnt <= '0;
        end else if (w_chg) begin
            r_fast     <= 1'b1;
            r_fast_cnt <= '0;
        end else if (tick_en) begin
            if (r_fast_cnt == FAST_MAX) begin
                r_fast     <= ~r_fast;
                r_fast_cnt <= '0;
            end else begin
                r_fast_cnt <= r_fast_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slow     <= 1'b1;
            r_slow_cnt <= '0;
        end else if (w_chg) begin
            r_slow     <= 1'b1;
            r_slow_cnt <= '0;
        end else if (tick_en) begin
            if (r_slow_cnt == SLOW_MAX) begin
                r_slow     <= ~r_slow;
                r_slow_cnt <= '0;
            end else begin
                r_slow_cnt <= r_slow_cnt + 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign fast_blink = r_fast;
    assign slow_blink = r_slow;

endmodule
